// File: rtl/gate_multi_multi_seq.sv
// Registered multi-input gate driving OUTPUT_COUNT outputs as a replicated level or a
// one-hot trigger sweep, with a per-tick limiter on how many result changes may fire.
module gate_multi_multi_seq #(
  parameter int INPUT_COUNT  = 2,
  parameter int OUTPUT_COUNT = 2,
  parameter int FUNC         = 1,
  parameter int OUT_MODE     = 0,
  parameter int MAX_FIRES    = 4
) (
  input  logic                    clk,
  input  logic                    logic_reset,
  input  logic                    tick,
  input  logic [INPUT_COUNT-1:0]  in,
  output logic [OUTPUT_COUNT-1:0] out,
  output logic                    result,
  output logic                    busy,
  output logic                    overflow
);

  localparam int CNT_W = (MAX_FIRES > 0) ? $clog2(MAX_FIRES + 1) : 1;
  localparam int IDX_W = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;

  function automatic logic gate_eval(input logic [INPUT_COUNT-1:0] v);
    case (FUNC)
      0:       gate_eval = &v;
      1:       gate_eval = |v;
      2:       gate_eval = ^v;
      3:       gate_eval = ~&v;
      4:       gate_eval = ~|v;
      default: gate_eval = ~^v;
    endcase
  endfunction

  logic             eval;
  logic             change;
  logic             absorb;
  logic             judge;
  logic             accept;
  logic             reject;
  logic [CNT_W-1:0] fire_cnt;
  logic [CNT_W-1:0] cnt_base;

  assign eval     = gate_eval(in);
  assign change   = (eval != result);
  // Tick clears the counter before the same-cycle event is judged.
  assign cnt_base = tick ? '0 : fire_cnt;
  assign judge    = change && !absorb;
  assign accept   = judge && ((MAX_FIRES == 0) || (cnt_base < CNT_W'(MAX_FIRES)));
  assign reject   = judge && !accept;

  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      result   <= gate_eval('0);
      fire_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      result   <= eval;
      fire_cnt <= (accept && (MAX_FIRES != 0)) ? cnt_base + CNT_W'(1) : cnt_base;
      overflow <= overflow | reject;
    end
  end

  generate
    if (OUT_MODE == 1) begin : g_pulse
      typedef enum logic {IDLE, SWEEP} state_t;
      state_t           state, state_n;
      logic [IDX_W-1:0] idx, idx_n;
      logic             pending, pending_n;

      always_ff @(posedge clk or posedge logic_reset) begin
        if (logic_reset) begin
          state   <= IDLE;
          idx     <= '0;
          pending <= 1'b0;
        end else begin
          state   <= state_n;
          idx     <= idx_n;
          pending <= pending_n;
        end
      end

      always_comb begin
        state_n   = state;
        idx_n     = idx;
        pending_n = pending;
        case (state)
          IDLE: begin
            if (accept) begin
              state_n = SWEEP;
              idx_n   = '0;
            end
          end
          default: begin
            if (idx == IDX_W'(OUTPUT_COUNT - 1)) begin
              // A queued (or just-accepted) event restarts the sweep with no gap.
              idx_n     = '0;
              pending_n = 1'b0;
              if (!(pending || accept)) state_n = IDLE;
            end else begin
              idx_n = idx + IDX_W'(1);
              if (accept) pending_n = 1'b1;
            end
          end
        endcase
      end

      assign absorb = (state == SWEEP) && pending;
      assign busy   = (state == SWEEP);
      assign out    = busy ? (OUTPUT_COUNT'(1) << idx) : '0;
    end else begin : g_level
      logic [OUTPUT_COUNT-1:0] level_q;

      always_ff @(posedge clk or posedge logic_reset) begin
        if (logic_reset) level_q <= '0;
        else if (accept) level_q <= {OUTPUT_COUNT{eval}};
      end

      assign absorb = 1'b0;
      assign busy   = 1'b0;
      assign out    = level_q;
    end
  endgenerate

endmodule
